edp_muldiv: RTL and testbench
=============================

Name: edp_muldiv

Overview:
- Parametrised multiply/divide sequencer for the EBOX data path.
- Replaces microcode-stepped AR/MQ shift-add and shift-subtract loops with an autonomous multi-cycle engine, started by a single request.
- Supports signed and unsigned operation at any word width; default is the 36-bit PDP-10 word.
- Bit numbering is big-endian throughout: bit 0 is the MSB, bit WIDTH-1 is the LSB.

Parameters:
- WIDTH, 36: operand width in bits. Minimum 4.
- CNT_W, 6: step-counter width. Must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 MULU, 01 MULS, 10 DIVU, 11 DIVS.
- a_hi  input  WIDTH  dividend high word; ignored for multiply.
- a_lo  input  WIDTH  multiplicand, or dividend low word.
- b  input  WIDTH  multiplier, or divisor.
- busy  output  1  high from the edge that accepts start until done falls.
- done  output  1  one-cycle completion pulse.
- overflow  output  1  divide check; valid with done.
- hi  output  WIDTH  product high word, or remainder.
- lo  output  WIDTH  product low word, or quotient.

Behaviour:
- Reset, whenever asserted: state IDLE; busy, done, overflow, hi and lo all 0. An operation in progress is abandoned with no done pulse.
- States: IDLE, CHECK, RUN, FIX, DONE.
- IDLE:
  - On start=1, capture op, the operand magnitudes and the result sign; go to CHECK.
  - For signed ops, magnitude = two's-complement absolute value. -2**(WIDTH-1) yields an unsigned magnitude of 2**(WIDTH-1).
  - For unsigned ops, operands are used unchanged.
- CHECK (1 cycle):
  - Divide only: overflow if b==0, or magnitude(dividend high) >= magnitude(b). On overflow, go to DONE with hi=a_hi, lo=a_lo (dividend returned unchanged) and overflow=1.
  - Otherwise load the step counter to WIDTH and go to RUN.
- RUN (one radix-2 step per cycle; go to FIX when the counter reaches 0):
  - Multiply: add the multiplicand into the 2W accumulator when the multiplier LSB is 1, then shift right.
  - Divide: non-restoring shift-subtract on a 2W remainder:quotient pair.
- FIX (1 cycle):
  - Divide: restore a negative remainder.
  - Negate results per sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = dividend sign (sign of a_hi for DIVS).
  - Go to DONE.
- DONE (1 cycle): done=1; hi, lo and overflow present results; then return to IDLE.
  - hi, lo and overflow hold until the next accepted start, which clears overflow.
- Latency, counted from the edge that samples start:
  - Normal op: done is high in cycle WIDTH+3.
  - Divide overflow: done is high in cycle 3.
- start while busy is ignored; no queueing.
- Widths:
  - Internal accumulator is 2*WIDTH+1 bits.
  - MULS of -2**(WIDTH-1) by itself gives +2**(2W-2), which is representable.
  - DIVS with quotient magnitude 2**(WIDTH-1) and a positive sign is flagged overflow in FIX: done is still produced, overflow=1, and hi/lo hold the dividend.

Optional Feature:
- Macro EDP_MULDIV_EARLY_EXIT_EN.
- Defined: during multiply RUN, when the remaining unshifted multiplier bits are all 0, the accumulator is shifted by the remaining count in a single cycle and the block goes straight to FIX. Latency becomes 3 + (index of the highest set multiplier bit, counted from the LSB, plus 1). A zero multiplier completes in 4 cycles. Divide is unaffected.
- Undefined: fixed latency as stated above.

Decomposition:
- Package edp_pkg holds:
  - the op encoding localparams OP_MULU, OP_MULS, OP_DIVU, OP_DIVS;
  - the state encoding enum;
  - a width-generic magnitude/negate function.
- One sub-module, edp_muldiv_step: combinational single radix-2 step (add/subtract plus shift) on the 2W+1 accumulator, parametrised by WIDTH.
- The parent module holds the FSM, the counter and the result registers.

Test Plan (WIDTH=36):
- MULU a_lo=36'o777777777777, b=2 → hi=1, lo=36'o777777777776, overflow=0, done in cycle 39, busy high cycles 1–39.
- MULS a_lo=-3, b=5 → hi=36'o777777777777, lo=36'o777777777761 (-15). Also MULS with both operands 36'o400000000000 → hi=36'o200000000000, lo=0.
- DIVU {a_hi=0, a_lo=100}, b=7 → lo=14, hi=2. DIVS {a_hi=all ones, a_lo=-100}, b=7 → lo=-14, hi=-2.
- DIVU a_hi=5, b=5 → overflow=1, hi=5, lo=a_lo, done in cycle 3. Divide by b=0 gives the same response.
- Reset mid-operation: assert reset in cycle 10 of a MULU → all outputs 0 immediately, no done pulse; a new start after deassertion completes correctly. Separately, start pulsed while busy → ignored, first result unchanged.
- With EDP_MULDIV_EARLY_EXIT_EN: MULU b=1 → done in cycle 4. b=0 → hi=lo=0, done in cycle 4.

Source files
------------

// File: rtl/edp_muldiv_pkg.sv
//==============================================================================
// Module  : edp_pkg (package)
// Purpose : Shared definitions for the EBOX multiply/divide sequencer:
//           operation encoding, FSM state encoding and a width-generic
//           conditional two's-complement negate used for magnitudes and
//           for re-applying result signs.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package edp_pkg;

    // Operation encoding: op[1] selects divide, op[0] selects signed.
    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MULS = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_DIVS = 2'b11;

    // Widest operand the negate helper handles. Callers size-cast into and
    // out of this width, so any 2*WIDTH up to this value is supported.
    localparam int EDP_MAX_W = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_RUN   = 3'd2,
        ST_FIX   = 3'd3,
        ST_DONE  = 3'd4
    } edp_state_t;

    // Returns -i_val when i_neg is set, else i_val. Only the low bits the
    // caller keeps are meaningful; two's-complement negation of the low N
    // bits never depends on bits above N.
    function automatic logic [EDP_MAX_W-1:0] edp_cneg(
        input logic [EDP_MAX_W-1:0] i_val,
        input logic                 i_neg
    );
        return i_neg ? (~i_val + EDP_MAX_W'(1)) : i_val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/edp_muldiv_step.sv
//==============================================================================
// Module  : edp_muldiv_step
// Purpose : One combinational radix-2 step on the 2*WIDTH+1 accumulator.
//           Multiply: {carry,hi,lo}; add i_addend into hi when lo[0] is set,
//           then shift the whole accumulator right by one.
//           Divide (non-restoring): {rem(WIDTH+1), quot(WIDTH)}; shift the
//           pair left, subtract the divisor if the remainder was non-negative
//           or add it if negative, and shift in the new quotient bit.
// Ports   : i_acc    - current accumulator
//           i_addend - multiplicand magnitude or divisor magnitude
//           i_div    - 1 = divide step, 0 = multiply step
//           o_acc    - accumulator after the step
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module edp_muldiv_step #(
    parameter int WIDTH = 36
) (
    input  logic [2*WIDTH:0]  i_acc,
    input  logic [WIDTH-1:0]  i_addend,
    input  logic              i_div,
    output logic [2*WIDTH:0]  o_acc
);

    logic [WIDTH:0] w_mul_sum;
    logic [WIDTH:0] w_div_shl;
    logic [WIDTH:0] w_div_rem;

    always_comb begin
        w_mul_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                  + (i_acc[0] ? {1'b0, i_addend} : {(WIDTH+1){1'b0}});

        // The remainder stays within [-divisor, divisor), so arithmetic
        // modulo 2**(WIDTH+1) is exact even though the shift drops its MSB.
        w_div_shl = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_div_rem = i_acc[2*WIDTH] ? (w_div_shl + {1'b0, i_addend})
                                   : (w_div_shl - {1'b0, i_addend});

        if (i_div) begin
            o_acc = {w_div_rem, i_acc[WIDTH-2:0], ~w_div_rem[WIDTH]};
        end else begin
            o_acc = {1'b0, w_mul_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/edp_muldiv.sv
//==============================================================================
// Module  : edp_muldiv
// Purpose : Autonomous multi-cycle multiply/divide sequencer for the EBOX
//           data path. Signed and unsigned, any WIDTH >= 4 (2**CNT_W > WIDTH).
//           Operands are reduced to magnitudes, processed one radix-2 step
//           per cycle, and the result signs are re-applied in FIX.
// Ports   : clk, reset (async, active high)
//           start, op[1:0], a_hi, a_lo, b     - request
//           busy, done, overflow, hi, lo      - status and results
// Options : EDP_MULDIV_EARLY_EXIT_EN - multiply finishes as soon as the
//           remaining multiplier bits are all zero.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module edp_muldiv
    import edp_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  a_hi,
    input  logic [WIDTH-1:0]  a_lo,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int c_ACC_W = 2*WIDTH + 1;

    edp_state_t          r_state;
    edp_state_t          w_state_nxt;
    logic [1:0]          r_op;
    logic [c_ACC_W-1:0]  r_acc;
    logic [WIDTH-1:0]    r_addend;
    logic [WIDTH-1:0]    r_dvd_hi;
    logic [WIDTH-1:0]    r_dvd_lo;
    logic                r_sign_q;
    logic                r_sign_r;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;

    logic [WIDTH-1:0]    w_mag_b;
    logic [WIDTH-1:0]    w_mag_alo;
    logic [2*WIDTH-1:0]  w_mag_dvd;
    logic [c_ACC_W-1:0]  w_step;
    logic [c_ACC_W-1:0]  w_run_acc;
    logic                w_early;
    logic                w_check_ovf;
    logic                w_run_last;
    logic [WIDTH-1:0]    w_rem_fix;
    logic                w_q_ovf;
    logic [2*WIDTH-1:0]  w_prod;
    logic [WIDTH-1:0]    w_res_hi;
    logic [WIDTH-1:0]    w_res_lo;

    // ---------------------------------------------------------------- operands
    // For signed ops the dividend is a 2*WIDTH two's-complement value whose
    // sign lives in a_hi; the most negative value maps to 2**(n-1).
    always_comb begin
        w_mag_b   = WIDTH'(edp_cneg(EDP_MAX_W'(b), op[0] & b[WIDTH-1]));
        w_mag_alo = WIDTH'(edp_cneg(EDP_MAX_W'(a_lo), op[0] & a_lo[WIDTH-1]));
        w_mag_dvd = (2*WIDTH)'(edp_cneg(EDP_MAX_W'({a_hi, a_lo}),
                                        op[0] & a_hi[WIDTH-1]));
    end

    // ---------------------------------------------------------------- step
    edp_muldiv_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .i_acc    (r_acc),
        .i_addend (r_addend),
        .i_div    (r_op[1]),
        .o_acc    (w_step)
    );

`ifdef EDP_MULDIV_EARLY_EXIT_EN
    // After this step r_cnt-1 multiplier bits remain in acc[r_cnt-2:0]; if
    // they are all zero the rest of the loop is a pure shift.
    logic [CNT_W-1:0]  w_rem;
    logic [WIDTH-1:0]  w_rem_mask;

    always_comb begin
        w_rem      = r_cnt - CNT_W'(1);
        w_rem_mask = ~({WIDTH{1'b1}} << w_rem);
        w_early    = ~r_op[1] && ((w_step[WIDTH-1:0] & w_rem_mask) == '0);
        w_run_acc  = w_early ? (w_step >> w_rem) : w_step;
    end
`else
    assign w_early   = 1'b0;
    assign w_run_acc = w_step;
`endif

    // ---------------------------------------------------------------- checks
    assign w_check_ovf = r_op[1] && ((r_addend == '0)
                         || (r_acc[2*WIDTH-1:WIDTH] >= r_addend));
    assign w_run_last  = w_early || (r_cnt == CNT_W'(1));

    // ---------------------------------------------------------------- fix-up
    always_comb begin
        // Non-restoring leaves a negative remainder one divisor short.
        w_rem_fix = r_acc[2*WIDTH] ? (r_acc[2*WIDTH-1:WIDTH] + r_addend)
                                   : r_acc[2*WIDTH-1:WIDTH];
        // Signed quotient must fit: magnitude above 2**(W-1), or exactly
        // 2**(W-1) with a positive sign, is not representable.
        w_q_ovf   = r_op[1] & r_op[0] & r_acc[WIDTH-1]
                  & ((r_acc[WIDTH-2:0] != '0) | ~r_sign_q);
        w_prod    = (2*WIDTH)'(edp_cneg(EDP_MAX_W'(r_acc[2*WIDTH-1:0]), r_sign_q));
        if (r_op[1]) begin
            w_res_hi = WIDTH'(edp_cneg(EDP_MAX_W'(w_rem_fix), r_sign_r));
            w_res_lo = WIDTH'(edp_cneg(EDP_MAX_W'(r_acc[WIDTH-1:0]), r_sign_q));
        end else begin
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != ST_IDLE);
        done        = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_CHECK;
            // A divide check still passes through FIX (which returns the
            // dividend when r_ovf is set), giving a fixed 3-cycle response.
            ST_CHECK: w_state_nxt = w_check_ovf ? ST_FIX : ST_RUN;
            ST_RUN:   if (w_run_last) w_state_nxt = ST_FIX;
            ST_FIX:   w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_acc    <= '0;
            r_addend <= '0;
            r_dvd_hi <= '0;
            r_dvd_lo <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_ovf    <= 1'b0;
                        r_dvd_hi <= a_hi;
                        r_dvd_lo <= a_lo;
                        if (op[1]) begin
                            r_acc    <= {1'b0, w_mag_dvd};
                            r_addend <= w_mag_b;
                            r_sign_q <= op[0] & (a_hi[WIDTH-1] ^ b[WIDTH-1]);
                            r_sign_r <= op[0] & a_hi[WIDTH-1];
                        end else begin
                            r_acc    <= {{(WIDTH+1){1'b0}}, w_mag_b};
                            r_addend <= w_mag_alo;
                            r_sign_q <= op[0] & (a_lo[WIDTH-1] ^ b[WIDTH-1]);
                            r_sign_r <= 1'b0;
                        end
                    end
                end
                ST_CHECK: begin
                    r_cnt <= CNT_W'(WIDTH);
                    r_ovf <= w_check_ovf;
                end
                ST_RUN: begin
                    r_acc <= w_run_acc;
                    r_cnt <= w_early ? '0 : (r_cnt - CNT_W'(1));
                end
                ST_FIX: begin
                    if (r_ovf || w_q_ovf) begin
                        r_ovf <= 1'b1;
                        r_hi  <= r_dvd_hi;
                        r_lo  <= r_dvd_lo;
                    end else begin
                        r_hi  <= w_res_hi;
                        r_lo  <= w_res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign overflow = r_ovf;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_edp_muldiv.sv
`default_nettype none

module tb_edp_muldiv;
    import edp_pkg::*;

    localparam int W = 36;
    localparam logic [W-1:0] ONES = '1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a_hi, a_lo, b;
    logic          busy, done, overflow;
    logic [W-1:0]  hi, lo;

    always #5 clk = ~clk;

    edp_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_hi     (a_hi),
        .a_lo     (a_lo),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a_hi, a_lo, b;
        logic [W-1:0] e_hi, e_lo;
        logic         e_ovf;
        int           e_cyc;
    } vec_t;

    vec_t vecs[16];
    int   checks = 0;
    int   errors = 0;

    task automatic check_v(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected completion cycle for a multiply with multiplier m.
    function automatic int mul_lat(input logic [1:0] o, input logic [W-1:0] m);
`ifdef EDP_MULDIV_EARLY_EXIT_EN
        logic [W-1:0] mag;
        int k;
        mag = (o == OP_MULS && m[W-1]) ? -m : m;
        k = 0;
        for (int i = 0; i < W; i++) if (mag[i]) k = i + 1;
        return (k == 0) ? 4 : 3 + k;
`else
        return (o[1] == 1'b0 && m == m) ? W + 3 : W + 3;
`endif
    endfunction

    function automatic vec_t mk(input logic [1:0] o, input logic [W-1:0] ah, input logic [W-1:0] al,
                                input logic [W-1:0] bb, input logic [W-1:0] eh, input logic [W-1:0] el,
                                input logic eo, input int ec);
        vec_t v;
        v.op = o; v.a_hi = ah; v.a_lo = al; v.b = bb;
        v.e_hi = eh; v.e_lo = el; v.e_ovf = eo; v.e_cyc = ec;
        return v;
    endfunction

    // Issue one request, follow it to done, check results and the idle cycle
    // after. If pulse_at > 0 a second start with other operands is raised in
    // that cycle while the engine is busy.
    task automatic run(input vec_t v, input string tag, input int pulse_at);
        int cyc;
        int busy_bad;
        bit got;
        @(negedge clk);
        op = v.op; a_hi = v.a_hi; a_lo = v.a_lo; b = v.b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1; busy_bad = 0; got = 1'b0;
        while (!got && cyc <= 200) begin
            if (!busy) busy_bad++;
            if (done) begin
                got = 1'b1;
            end else begin
                if (cyc == pulse_at) begin
                    start = 1'b1; op = OP_MULU; a_lo = ~a_lo; b = b ^ 36'h5;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        check_i({tag, " done_cycle"}, cyc, v.e_cyc);
        check_i({tag, " busy"}, busy_bad, 0);
        check_v({tag, " hi"}, hi, v.e_hi);
        check_v({tag, " lo"}, lo, v.e_lo);
        check_v({tag, " overflow"}, overflow, v.e_ovf);
        @(posedge clk); #1;
        check_v({tag, " idle busy/done"}, {busy, done}, 2'b00);
        check_v({tag, " hold hi"}, hi, v.e_hi);
        check_v({tag, " hold lo"}, lo, v.e_lo);
        check_v({tag, " hold ovf"}, overflow, v.e_ovf);
    endtask

    initial begin
        int bad;
        reset = 1'b1; start = 1'b0; op = '0; a_hi = '0; a_lo = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_v("reset busy", busy, 1'b0);
        check_v("reset done", done, 1'b0);
        check_v("reset overflow", overflow, 1'b0);
        check_v("reset hi", hi, '0);
        check_v("reset lo", lo, '0);
        @(negedge clk) reset = 1'b0;

        vecs[0]  = mk(OP_MULU, '0, 36'o777777777777, 36'd2, 36'd1, 36'o777777777776, 1'b0, mul_lat(OP_MULU, 36'd2));
        vecs[1]  = mk(OP_MULS, '0, 36'hFFFFFFFFD, 36'd5, ONES, 36'o777777777761, 1'b0, mul_lat(OP_MULS, 36'd5));
        vecs[2]  = mk(OP_MULS, '0, 36'o400000000000, 36'o400000000000, 36'o200000000000, '0, 1'b0,
                      mul_lat(OP_MULS, 36'o400000000000));
        vecs[3]  = mk(OP_MULU, '0, ONES, ONES, 36'hFFFFFFFFE, 36'd1, 1'b0, mul_lat(OP_MULU, ONES));
        vecs[4]  = mk(OP_MULS, '0, 36'd7, ONES, ONES, 36'hFFFFFFFF9, 1'b0, mul_lat(OP_MULS, ONES));
        vecs[5]  = mk(OP_MULU, '0, 36'd12345, 36'd1, '0, 36'd12345, 1'b0, mul_lat(OP_MULU, 36'd1));
        vecs[6]  = mk(OP_MULU, '0, 36'd12345, 36'd0, '0, '0, 1'b0, mul_lat(OP_MULU, 36'd0));
        vecs[7]  = mk(OP_DIVU, '0, 36'd100, 36'd7, 36'd2, 36'd14, 1'b0, W + 3);
        vecs[8]  = mk(OP_DIVS, ONES, 36'hFFFFFFF9C, 36'd7, 36'hFFFFFFFFE, 36'hFFFFFFFF2, 1'b0, W + 3);
        vecs[9]  = mk(OP_DIVS, '0, 36'd100, 36'hFFFFFFFF9, 36'd2, 36'hFFFFFFFF2, 1'b0, W + 3);
        vecs[10] = mk(OP_DIVS, ONES, 36'hFFFFFFF9C, 36'hFFFFFFFF9, 36'hFFFFFFFFE, 36'd14, 1'b0, W + 3);
        vecs[11] = mk(OP_DIVU, 36'd1, '0, 36'd3, 36'd1, 36'h555555555, 1'b0, W + 3);
        vecs[12] = mk(OP_DIVU, 36'd5, 36'd123, 36'd5, 36'd5, 36'd123, 1'b1, 3);
        vecs[13] = mk(OP_DIVU, '0, 36'd55, 36'd0, '0, 36'd55, 1'b1, 3);
        vecs[14] = mk(OP_DIVS, '0, 36'o400000000000, 36'd1, '0, 36'o400000000000, 1'b1, W + 3);
        vecs[15] = mk(OP_DIVS, ONES, 36'o400000000000, 36'd1, '0, 36'o400000000000, 1'b0, W + 3);

        for (int i = 0; i < 16; i++) begin
            run(vecs[i], $sformatf("v%0d", i), 0);
        end

        // start pulsed while busy must be ignored
        run(mk(OP_MULU, '0, 36'd1000, 36'o400000000003, 36'd500, 36'd3000, 1'b0,
               mul_lat(OP_MULU, 36'o400000000003)), "busy_start", 5);

        // reset in cycle 10 of a multiply abandons it
        @(negedge clk);
        op = OP_MULU; a_hi = '0; a_lo = 36'd9; b = 36'o400000000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_v("pre-reset busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check_v("mid-reset busy", busy, 1'b0);
        check_v("mid-reset done", done, 1'b0);
        check_v("mid-reset overflow", overflow, 1'b0);
        check_v("mid-reset hi", hi, '0);
        check_v("mid-reset lo", lo, '0);
        @(negedge clk) reset = 1'b0;
        bad = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (done || busy) bad++;
        end
        check_i("abandoned op activity", bad, 0);
        run(mk(OP_MULU, '0, 36'd9, 36'o400000000000, 36'd4, 36'o400000000000, 1'b0,
               mul_lat(OP_MULU, 36'o400000000000)), "after_reset", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
